nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs a full-width add or subtract by time-multiplexing one external 4-bit carry-lookahead slice (cla4-style: a[3:0], b[3:0], cin -> sum[3:0], cout), one nibble per clock, LSB nibble first.
- Trades latency for area where a cla32 is too large.
- Valid/ready handshake on operand input and on result output.
- Slice is purely combinational; the controller registers the slice carry between nibbles.

---
 rtl/nibble_serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor sequencer: drives one external 4-bit CLA slice
// once per clock, LSB nibble first, with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl #(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int IDXW = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              carry;
  logic              cout_reg;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      cout_reg  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the operand is inverted once here.
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            sum_reg  <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg[4*idx +: 4] <= slice_sum;
          carry               <= slice_cout;
          if (idx == IDXW'(NIB - 1)) begin
            cout_reg  <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: outputs get a default before the conditional so no latch is inferred.
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[4*idx +: 4];
      slice_b   = b_reg[4*idx +: 4];
      slice_cin = carry;
    end
  end

  // Carry into the MSB is a^b^sum at that bit; XOR with carry out gives overflow.
  assign ovf  = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_reg[WIDTH-1] ^ cout_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: directed corner cases plus random
// add/sub traffic, checked against a plain-arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int W = 32;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [3:0]   slice_a, slice_b, slice_sum;
  logic         slice_cin, slice_cout;
  logic         out_valid, out_ready = 1'b1, cout, ovf, busy;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  // 8-bit instance with its own slice.
  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [3:0] slice_a8, slice_b8, slice_sum8;
  logic       slice_cin8, slice_cout8;
  logic       out_valid8, out_ready8 = 1'b1, cout8, ovf8, busy8;

  nibble_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .slice_a(slice_a8), .slice_b(slice_b8), .slice_cin(slice_cin8),
    .slice_sum(slice_sum8), .slice_cout(slice_cout8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );
  assign {slice_cout8, slice_sum8} = {1'b0, slice_a8} + {1'b0, slice_b8} + {4'b0, slice_cin8};

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned arithmetic for sum/cout, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] ai, bi, input logic ci, si);
    exp_t   r;
    longint ua = ai, ub = bi;
    longint sa = $signed(ai), sbv = $signed(bi);
    longint full, sfull;
    longint smax = (64'sd1 <<< (W - 1)) - 1;
    longint smin = -(64'sd1 <<< (W - 1));
    if (si) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
      sfull  = sa - sbv;
    end else begin
      full   = ua + ub + longint'(ci);
      r.cout = full[W];
      sfull  = sa + sbv + longint'(ci);
    end
    r.sum = full[W-1:0];
    r.ovf = (sfull > smax) || (sfull < smin);
    r.acc = 0;
    return r;
  endfunction

  // Carry entering nibble i: carry out of the low 4*i bits of the effective sum.
  function automatic logic exp_cin(input logic [W-1:0] ai, bi, input logic ci, si, input int i);
    longint mask = (64'd1 << (4 * i)) - 1;
    longint be   = si ? longint'(~bi) : longint'(bi);
    longint t    = (longint'(ai) & mask) + (be & mask) + (si ? 64'd1 : longint'(ci));
    return t[4*i];
  endfunction

  task automatic send(input logic [W-1:0] ai, bi, input logic ci, si,
                      input bit push, input bit trace);
    int   n = 0;
    exp_t e;
    logic [W-1:0] be;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e     = model(ai, bi, ci, si);
      e.acc = cyc;
      sb.push_back(e);
    end
    if (trace) begin
      be = si ? ~bi : bi;
      check("run_busy", 64'(busy), 64'd1);
      check("run_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < N; i++) begin
        check("slice_a", 64'(slice_a), 64'((ai >> (4 * i)) & 32'hF));
        check("slice_b", 64'(slice_b), 64'((be >> (4 * i)) & 32'hF));
        check("slice_cin", 64'(slice_cin), 64'(exp_cin(ai, bi, ci, si, i)));
        if (i < N - 1) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) check("unexpected_out_valid", 64'd1, 64'd0);
        else                check("latency", 64'(cyc - sb[0].acc), 64'(N));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("sum", 64'(sum), 64'(mon_e.sum));
        check("cout", 64'(cout), 64'(mon_e.cout));
        check("ovf", 64'(ovf), 64'(mon_e.ovf));
      end
    end
    ov_prev = out_valid;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    exp_t ea;
    int   n;
    int   acc8;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
    check("rst_slice", {55'd0, slice_a, slice_b, slice_cin}, 64'd0);
    rst = 1'b0;

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1);
    drain();
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1, 1);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1);
    drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1, 1);
    drain();

    // Backpressure in DONE with a competing request on the input.
    out_ready = 1'b0;
    ea = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 1, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid_seen", 64'(out_valid), 64'd1);
    a = 32'hDEAD_BEEF; b = 32'h1111_1111; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum_hold", 64'(sum), 64'(ea.sum));
      check("bp_cout_ovf_hold", {62'd0, cout, ovf}, {62'd0, ea.cout, ea.ovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b1, 1, 1);
    drain();

    // Reset while idx = 3: partial result must vanish.
    send(32'hCAFE_F00D, 32'h0123_4567, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_slice", {55'd0, slice_a, slice_b, slice_cin}, 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    send(32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 1, 1);
    drain();

    // 8-bit instance.
    a8 = 8'hF0; b8 = 8'h10; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    acc8 = cyc;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", 64'(cyc - acc8), 64'd2);
    check("w8_sum", 64'(sum8), 64'd0);
    check("w8_cout", 64'(cout8), 64'd1);
    check("w8_ovf", 64'(ovf8), 64'd0);
    @(posedge clk); #1;

    // Random traffic with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = $urandom();
      rb = (k % 5 == 0) ? ~ra : $urandom();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, 1, 1);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
